csa_seq_adder: RTL and testbench
================================

CSA_SEQ_ADDER -- requirements
Module: csa_seq_adder

Interface
REQ-001 Parameter NUM_WORDS, default 4: number of 16-bit slices; operand width W = 16*NUM_WORDS; legal range 1..8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to start an addition; accepted only when ready=1.
REQ-005 a  input  W  operand A; sampled on the accepted start cycle.
REQ-006 b  input  W  operand B; sampled on the accepted start cycle.
REQ-007 carry_in  input  1  carry into slice 0; sampled on the accepted start cycle.
REQ-008 ready  output  1  high only in IDLE; start is accepted when start=1 and ready=1.
REQ-009 busy  output  1  high in ADD and DONE.
REQ-010 done  output  1  one-cycle pulse; sum, carry_out and overflow are valid and updated in this cycle.
REQ-011 sum  output  W  registered result of a+b+carry_in, modulo 2^W.
REQ-012 carry_out  output  1  registered carry out of bit W-1.
REQ-013 overflow  output  1  registered two's-complement overflow of the full W-bit add.

Function
REQ-014 Block SHALL contain exactly one 16-bit csa instance (ports a, b, carry_in, sum, carry_out) and SHALL reuse it once per slice.
REQ-015 FSM states: IDLE, ADD, DONE; IDLE->ADD on accepted start; ADD->DONE after slice NUM_WORDS-1; DONE->IDLE unconditionally after one cycle.
REQ-016 The accepted start at cycle T SHALL capture a, b and carry_in into internal operand registers; later changes to the inputs have no effect on the operation in flight.
REQ-017 In ADD cycle T+1+k, k=0..NUM_WORDS-1, csa inputs SHALL be a[16k+15:16k], b[16k+15:16k] and the carry: captured carry_in for k=0, otherwise the registered csa carry_out of slice k-1.
REQ-018 The slice-k csa sum SHALL be written to internal accumulator bits [16k+15:16k] at the end of cycle T+1+k.
REQ-019 done=1 at cycle T+NUM_WORDS+1 (latency NUM_WORDS+1 from the accepted start); ready returns to 1 at T+NUM_WORDS+2.
REQ-020 sum, carry_out and overflow SHALL change only in the done cycle and SHALL hold until the next done or rst.
REQ-021 overflow SHALL equal (a[W-1]==b[W-1]) and (sum[W-1]!=a[W-1]), computed from the captured operands.
REQ-022 start while busy=1 SHALL be ignored and not queued; start in the DONE cycle SHALL be ignored.
REQ-023 start held high continuously SHALL produce back-to-back operations spaced NUM_WORDS+2 cycles apart.
REQ-024 Arithmetic is unsigned modulo 2^W; the all-ones plus carry_in=1 case wraps to sum=0 with carry_out=1.

Reset
REQ-025 With rst=1 at a rising edge: state=IDLE, ready=1 from the next cycle, busy=0, done=0, sum=0, carry_out=0, overflow=0, and the accumulator and operand registers cleared.
REQ-026 rst SHALL take priority over start and over every FSM transition.
REQ-027 rst during ADD or DONE SHALL abort the operation, with no done pulse and no output update.

Verification (NUM_WORDS=4, W=64)
REQ-028 a=0, b=0, carry_in=1, start at T -> done at T+5, sum=0x1, carry_out=0, overflow=0.
REQ-029 a=0x000000000000FFFF, b=0x1, carry_in=0 -> sum=0x0000000000010000, carry_out=0; the carry crosses the slice 0/1 boundary.
REQ-030 a=0xFFFFFFFFFFFFFFFF, b=0, carry_in=1 -> sum=0, carry_out=1, overflow=0.
REQ-031 a=0x7FFFFFFFFFFFFFFF, b=0x1, carry_in=0 -> sum=0x8000000000000000, overflow=1, carry_out=0; a=b=0x8000000000000000, carry_in=0 -> sum=0, carry_out=1, overflow=1.
REQ-032 start held high 20 cycles while a and b change every cycle -> done pulses exactly 6 cycles apart; each result matches the operands sampled on the cycle ready=1.
REQ-033 rst=1 in the third ADD cycle -> next cycle busy=0 and ready=1; done never pulses; sum=0, carry_out=0.

Source files
------------

// File: rtl/csa_seq_adder.sv
// rtl/csa_seq_adder.sv - sequential W-bit adder reusing one 16-bit carry-select slice
// One slice per ADD cycle; result registers update only on entry to DONE.

module csa (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        carry_out
);
  logic [8:0] lo;
  logic [8:0] hi0;
  logic [8:0] hi1;

  // Upper byte is precomputed for both incoming carries and selected by the low carry.
  assign lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'b0, carry_in};
  assign hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign hi1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;

  assign sum[7:0]             = lo[7:0];
  assign {carry_out, sum[15:8]} = lo[8] ? hi1 : hi0;
endmodule

module csa_seq_adder #(
  parameter int NUM_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [16*NUM_WORDS-1:0]   a,
  input  logic [16*NUM_WORDS-1:0]   b,
  input  logic                      carry_in,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic [16*NUM_WORDS-1:0]   sum,
  output logic                      carry_out,
  output logic                      overflow
);
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic                            carry_q, carry_d;
  logic [NUM_WORDS-1:0][15:0]      a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic                            cout_q, cout_d, ovf_q, ovf_d;
  logic [15:0]                     slice_sum;
  logic                            slice_cout;

  csa u_csa (
    .a         (a_q[idx_q]),
    .b         (b_q[idx_q]),
    .carry_in  (carry_q),
    .sum       (slice_sum),
    .carry_out (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = carry_in;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        acc_d[idx_q] = slice_sum;
        carry_d      = slice_cout;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = slice_cout;
          ovf_d   = (a_q[NUM_WORDS-1][15] == b_q[NUM_WORDS-1][15]) &&
                    (acc_d[NUM_WORDS-1][15] != a_q[NUM_WORDS-1][15]);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign busy      = (state_q == ADD) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_csa_seq_adder.sv
// tb/tb_csa_seq_adder.sv - directed vector bench for csa_seq_adder (NUM_WORDS=4)

module tb_csa_seq_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] a, b;
  logic        carry_in;
  logic        ready, busy, done;
  logic [63:0] sum;
  logic        carry_out, overflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[7];

  csa_seq_adder #(.NUM_WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(carry_in),
    .ready(ready), .busy(busy), .done(done), .sum(sum),
    .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [63:0] prev;
    int done_at;
    int n_done;
    prev    = sum;
    done_at = 0;
    n_done  = 0;
    chk($sformatf("v%0d_ready_before", id), 64'(ready), 64'd1);
    a = v.a; b = v.b; carry_in = v.cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~v.a; b = {$urandom, $urandom}; carry_in = ~v.cin;
    for (int i = 1; i <= 7; i++) begin
      if (i > 1) @(negedge clk);
      if (i == 1) begin
        chk($sformatf("v%0d_sum_hold", id), sum, prev);
        chk($sformatf("v%0d_busy", id), 64'(busy), 64'd1);
      end
      if (done) begin
        n_done++;
        if (done_at == 0) begin
          done_at = i;
          chk($sformatf("v%0d_sum", id), sum, v.s);
          chk($sformatf("v%0d_cout", id), 64'(carry_out), 64'(v.co));
          chk($sformatf("v%0d_ovf", id), 64'(overflow), 64'(v.ov));
        end
      end
      if (i == 6) chk($sformatf("v%0d_ready_after", id), 64'(ready), 64'd1);
    end
    chk($sformatf("v%0d_latency", id), 64'(done_at), 64'd5);
    chk($sformatf("v%0d_done_count", id), 64'(n_done), 64'd1);
  endtask

  logic [64:0] exp_q[$];
  logic [64:0] full;
  logic [63:0] ea;
  int          last_done;
  int          n_done;
  int          n_done2;

  initial begin
    vecs[0] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[5] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0};
    vecs[6] = '{64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_cout", 64'(carry_out), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // start during DONE must be dropped, not queued
    a = 64'h5; b = 64'h6; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("dn_is_done", 64'(done), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dn_ignored_ready", 64'(ready), 64'd1);
    chk("dn_ignored_busy", 64'(busy), 64'd0);
    chk("dn_sum", sum, 64'hB);

    // start held high with changing operands: back-to-back, 6 cycles apart
    last_done = -1; n_done = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < 20) begin
        start = 1'b1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        carry_in = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (ready && start) begin
        full = {1'b0, a} + {1'b0, b} + {64'b0, carry_in};
        exp_q.push_back(full);
      end
      if (done) begin
        n_done++;
        if (last_done >= 0) chk($sformatf("b2b_gap%0d", n_done), 64'(i - last_done), 64'd6);
        last_done = i;
        if (exp_q.size() > 0) begin
          full = exp_q.pop_front();
          chk($sformatf("b2b_sum%0d", n_done), sum, full[63:0]);
          chk($sformatf("b2b_cout%0d", n_done), 64'(carry_out), 64'(full[64]));
        end
      end
      @(negedge clk);
    end
    chk("b2b_done_count", 64'(n_done), 64'd4);

    // reset in third ADD cycle aborts the operation
    ea = 64'h1234_0000_0000_0001;
    chk("abort_prev_sum_nonzero", 64'(sum != 0), 64'd1);
    a = ea; b = ea; carry_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_sum", sum, 64'd0);
    chk("abort_cout", 64'(carry_out), 64'd0);
    n_done2 = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) n_done2++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(n_done2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
